// File: rtl/prep_pkg.sv
// prep_pkg: shared types and constants for the shape preprocessing scheduler.
//   prep_state_t    - scheduler FSM state encoding (also exported on dbg_state)
//   PREP_MAXSHP_DEF - default number of shape slots
//   enc_w()         - index width for an N-input priority encoder (min 1 bit)
package prep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } prep_state_t;

    localparam int PREP_MAXSHP_DEF = 16;

    function automatic int enc_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lsb_prio_enc.sv
// lsb_prio_enc: combinational priority encoder, lowest set bit wins.
// Ports:
//   vec  [N-1:0] in  - request vector
//   idx  [W-1:0] out - index of the lowest set bit of vec (0 when vec is zero)
//   none         out - high when vec is all zeros
module lsb_prio_enc #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         none
);

    // Walk from the top down so the last (lowest) set bit overwrites.
    always_comb begin
        idx  = '0;
        none = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx  = W'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/shape_prep_scheduler.sv
// shape_prep_scheduler: once per frame, walks the shapes needing recomputation
// in ascending order and runs each through the shared trig/rotate unit,
// writing results back to the shape register file.
// Build option: PREP_DIRTY_EN - when defined, only slots marked through
// dirty_set are recomputed; when undefined every slot is recomputed per frame
// and dirty_set is ignored.
// Ports:
//   clk, rst         in  - pixel clock, synchronous active-high reset
//   start            in  - end-of-frame pulse, launches a pass from IDLE
//   dirty_set        in  - per-slot edit pulses
//   rd_id            out - slot presented to the unit (== current slot)
//   unit_req         out - one-cycle request, unit latches slot rd_id
//   unit_valid       in  - one-cycle pulse, unit results valid (WAIT only)
//   wr_en, wr_id     out - write unit results into slot wr_id
//   busy             out - FSM not idle
//   done             out - pass complete pulse
//   overrun          out - start seen while busy (start is dropped)
//   dbg_state        out - current FSM state (prep_state_t encoding)
// Handshake: unit_req is high exactly one cycle (ISSUE); the unit must answer
// with exactly one unit_valid pulse no earlier than the following cycle. A
// unit_valid outside WAIT is ignored, so a late answer after reset is harmless.
module shape_prep_scheduler
    import prep_pkg::*;
#(
    parameter int MAXSHP = PREP_MAXSHP_DEF,
    parameter int IDW    = enc_w(MAXSHP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MAXSHP-1:0] dirty_set,
    output logic [IDW-1:0]    rd_id,
    output logic              unit_req,
    input  logic              unit_valid,
    output logic              wr_en,
    output logic [IDW-1:0]    wr_id,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic [2:0]        dbg_state
);

    prep_state_t       r_state;
    prep_state_t       w_next;
    logic [MAXSHP-1:0] r_pending;
    logic [IDW-1:0]    r_cur;
    logic [MAXSHP-1:0] w_load;
    logic [IDW-1:0]    w_enc_idx;
    logic              w_enc_none;

`ifdef PREP_DIRTY_EN
    // Edits accumulate here; a start hands them (plus same-cycle edits) to
    // the pass. Edits during a pass, even to the slot in flight, wait for the
    // next pass because only the IDLE+start cycle clears this register.
    logic [MAXSHP-1:0] r_dirty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dirty <= '1;
        end else if (r_state == ST_IDLE && start) begin
            r_dirty <= '0;
        end else begin
            r_dirty <= r_dirty | dirty_set;
        end
    end

    assign w_load = r_dirty | dirty_set;
`else
    logic w_unused_dirty_set;
    assign w_unused_dirty_set = ^dirty_set;
    assign w_load             = '1;
`endif

    lsb_prio_enc #(
        .N (MAXSHP),
        .W (IDW)
    ) u_enc (
        .vec  (r_pending),
        .idx  (w_enc_idx),
        .none (w_enc_none)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_cur     <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE:  if (start) r_pending <= w_load;
                ST_SCAN:  if (!w_enc_none) r_cur <= w_enc_idx;
                ST_WRITE: r_pending[r_cur] <= 1'b0;
                default:  ;
            endcase
        end
    end

    always_comb begin
        w_next   = r_state;
        unit_req = 1'b0;
        wr_en    = 1'b0;
        done     = 1'b0;
        busy     = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_SCAN;
            ST_SCAN:  w_next = w_enc_none ? ST_DONE : ST_ISSUE;
            ST_ISSUE: begin
                unit_req = 1'b1;
                w_next   = ST_WAIT;
            end
            ST_WAIT:  if (unit_valid) w_next = ST_WRITE;
            ST_WRITE: begin
                wr_en  = 1'b1;
                w_next = ST_SCAN;
            end
            ST_DONE:  begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    assign overrun   = start && (r_state != ST_IDLE);
    assign rd_id     = r_cur;
    assign wr_id     = r_cur;
    assign dbg_state = r_state;

endmodule
